// File: rtl/axp_mem_port_pkg.sv
// Shared definitions for the memory port: size masks, FSM states, lane helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package axp_mem_port_pkg;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_W = 8'h03;
  localparam logic [7:0] MASK_L = 8'h0F;
  localparam logic [7:0] MASK_Q = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RWAIT = 3'd2,
    WR    = 3'd3,
    RESP  = 3'd4
  } state_t;

  // Any mask outside the four legal sizes behaves as a full quadword
  function automatic logic [7:0] norm_mask(input logic [7:0] m);
    case (m)
      MASK_B, MASK_W, MASK_L: norm_mask = m;
      default:                norm_mask = MASK_Q;
    endcase
  endfunction

  // Low address bits that must be zero for natural alignment (n-1)
  function automatic logic [2:0] align_bits(input logic [7:0] m);
    case (m)
      MASK_B:  align_bits = 3'd0;
      MASK_W:  align_bits = 3'd1;
      MASK_L:  align_bits = 3'd3;
      default: align_bits = 3'd7;
    endcase
  endfunction

  // One mask bit per byte lane, widened to eight data bits per lane
  function automatic logic [63:0] byte_expand(input logic [7:0] m);
    byte_expand = '0;
    for (int i = 0; i < 8; i++) begin
      byte_expand[8*i +: 8] = {8{m[i]}};
    end
  endfunction

endpackage

// File: rtl/axp_mem_lane.sv
// Byte-lane datapath: alignment check, lane mask/shift, RMW merge, load extract/extend.
// Latency: purely combinational.
// Backpressure: none; the caller decides when results are sampled.
module axp_mem_lane
  import axp_mem_port_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  logic [7:0]  mask,
  input  logic        sext,
  input  logic [63:0] st_data,
  input  logic [63:0] rd_data,
  output logic        fault,
  output logic        quad,
  output logic [7:0]  lanes,
  output logic [63:0] st_shift,
  output logic [63:0] merged,
  output logic [63:0] ld_data
);

  logic [7:0]  nmask;
  logic [5:0]  sh;
  logic [63:0] lane_bits;
  logic [63:0] ext;

  // Place store data into its lanes and pull load data out of them
  always_comb begin
    nmask     = norm_mask(mask);
    sh        = {addr_lo, 3'b000};
    fault     = |(addr_lo & align_bits(nmask));
    quad      = (nmask == MASK_Q);
    lanes     = nmask << addr_lo;
    st_shift  = st_data << sh;
    lane_bits = byte_expand(lanes);
    merged    = (rd_data & ~lane_bits) | (st_shift & lane_bits);
    ext       = (rd_data >> sh) & byte_expand(nmask);
    if (sext && (nmask == MASK_L)) begin
      ld_data = {{32{ext[31]}}, ext[31:0]};
    end else begin
      ld_data = ext;
    end
  end

endmodule

// File: rtl/axp_mem_port.sv
// Core load/store responder on a 64-bit quadword bus; AXP_MEM_BYTE_ENABLE_EN adds bus_be and drops RMW.
// Latency (zero-wait bus): fault 1, quad store 2, load 3, partial store 4 (2 with byte enables).
// Backpressure: one request in flight; bus commands held until bus_ready, response held until rsp_ready.
module axp_mem_port
  import axp_mem_port_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic              req_sext,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_mask,
  input  logic [63:0]       req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_data,
  output logic              rsp_fault,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_write,
  output logic [ADDR_W-4:0] bus_addr,
  output logic [63:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [63:0]       bus_rdata
`ifdef AXP_MEM_BYTE_ENABLE_EN
  ,
  output logic [7:0]        bus_be
`endif
);

`ifdef AXP_MEM_BYTE_ENABLE_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_fault_q, rsp_fault_d;
  logic [63:0]         rsp_data_q, rsp_data_d;
  logic                bus_valid_q, bus_valid_d;
  logic                bus_write_q, bus_write_d;
  logic [ADDR_W-4:0]   bus_addr_q, bus_addr_d;
  logic [63:0]         bus_wdata_q, bus_wdata_d;
  logic [2:0]          r_addr_lo_q, r_addr_lo_d;
  logic [7:0]          r_mask_q, r_mask_d;
  logic                r_sext_q, r_sext_d;
  logic                r_store_q, r_store_d;
  logic [63:0]         r_data_q, r_data_d;

  logic                accept;
  logic [2:0]          ln_addr;
  logic [7:0]          ln_mask;
  logic                ln_sext;
  logic [63:0]         ln_data;
  logic                ln_fault, ln_quad;
  logic [7:0]          ln_lanes;
  logic [63:0]         ln_st_shift, ln_merged, ln_ld_data;

  assign accept = (state_q == IDLE) && req_valid && req_ready_q;

  // Lane logic sees the live request while idle and the held request afterwards
  always_comb begin
    if (state_q == IDLE) begin
      ln_addr = req_addr[2:0];
      ln_mask = req_mask;
      ln_sext = req_sext;
      ln_data = req_data;
    end else begin
      ln_addr = r_addr_lo_q;
      ln_mask = r_mask_q;
      ln_sext = r_sext_q;
      ln_data = r_data_q;
    end
  end

  axp_mem_lane u_lane (
    .addr_lo  (ln_addr),
    .mask     (ln_mask),
    .sext     (ln_sext),
    .st_data  (ln_data),
    .rd_data  (bus_rdata),
    .fault    (ln_fault),
    .quad     (ln_quad),
    .lanes    (ln_lanes),
    .st_shift (ln_st_shift),
    .merged   (ln_merged),
    .ld_data  (ln_ld_data)
  );

  // Next-state and next-output computation for the request FSM
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_fault_d = rsp_fault_q;
    rsp_data_d  = rsp_data_q;
    bus_valid_d = bus_valid_q;
    bus_write_d = bus_write_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    r_addr_lo_d = r_addr_lo_q;
    r_mask_d    = r_mask_q;
    r_sext_d    = r_sext_q;
    r_store_d   = r_store_q;
    r_data_d    = r_data_q;
    case (state_q)
      IDLE: if (accept) begin
        r_addr_lo_d = req_addr[2:0];
        r_mask_d    = req_mask;
        r_sext_d    = req_sext;
        r_store_d   = req_store;
        r_data_d    = req_data;
        bus_addr_d  = req_addr[ADDR_W-1:3];
        if (ln_fault) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b1;
          rsp_data_d  = '0;
        end else if (req_store && (BE_EN || ln_quad)) begin
          state_d     = WR;
          bus_valid_d = 1'b1;
          bus_write_d = 1'b1;
          bus_wdata_d = ln_st_shift;
        end else begin
          state_d     = RD;
          bus_valid_d = 1'b1;
          bus_write_d = 1'b0;
        end
      end
      RD: if (bus_ready) begin
        bus_valid_d = 1'b0;
        state_d     = RWAIT;
      end
      RWAIT: if (bus_rvalid) begin
        if (r_store_q) begin
          state_d     = WR;
          bus_valid_d = 1'b1;
          bus_write_d = 1'b1;
          bus_wdata_d = ln_merged;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b0;
          rsp_data_d  = ln_ld_data;
        end
      end
      WR: if (bus_ready) begin
        bus_valid_d = 1'b0;
        bus_write_d = 1'b0;
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_fault_d = 1'b0;
        rsp_data_d  = '0;
      end
      RESP: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        rsp_fault_d = 1'b0;
        rsp_data_d  = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset drops any held request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_data_q  <= '0;
      bus_valid_q <= 1'b0;
      bus_write_q <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      r_addr_lo_q <= '0;
      r_mask_q    <= '0;
      r_sext_q    <= 1'b0;
      r_store_q   <= 1'b0;
      r_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_data_q  <= rsp_data_d;
      bus_valid_q <= bus_valid_d;
      bus_write_q <= bus_write_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      r_addr_lo_q <= r_addr_lo_d;
      r_mask_q    <= r_mask_d;
      r_sext_q    <= r_sext_d;
      r_store_q   <= r_store_d;
      r_data_q    <= r_data_d;
    end
  end

`ifdef AXP_MEM_BYTE_ENABLE_EN
  logic [7:0] bus_be_q, bus_be_d;

  // Byte enables: store lane mask for writes, all lanes for reads
  always_comb begin
    bus_be_d = bus_be_q;
    if (accept && !ln_fault) begin
      bus_be_d = req_store ? ln_lanes : 8'hFF;
    end
  end

  // Byte-enable register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) bus_be_q <= '0;
    else          bus_be_q <= bus_be_d;
  end

  assign bus_be = bus_be_q;
`endif

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_data  = rsp_data_q;
  assign bus_valid = bus_valid_q;
  assign bus_write = bus_write_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_axp_mem_port.sv
// Bench for axp_mem_port: table-driven loads/stores/faults, stalls and mid-transaction reset.
// Latency: responses timed from the request accept edge.
// Backpressure: exercised through bus_ready and rsp_ready stalls.
module tb_axp_mem_port;
  localparam int ADDR_W = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid = 1'b0, req_store = 1'b0, req_sext = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [7:0]        req_mask = '0;
  logic [63:0]       req_data = '0;
  logic              req_ready, rsp_valid, rsp_fault;
  logic              rsp_ready = 1'b1;
  logic [63:0]       rsp_data;
  logic              bus_valid, bus_write;
  logic              bus_ready = 1'b1;
  logic [ADDR_W-4:0] bus_addr;
  logic [63:0]       bus_wdata;
  logic [63:0]       bus_rdata = '0;
  logic              bus_rvalid;
`ifdef AXP_MEM_BYTE_ENABLE_EN
  logic [7:0]        bus_be;
  logic [7:0]        last_wbe = '0;
`endif

  int vectors = 0;
  int errors  = 0;
  logic [64:0] exp_q [$];   // {fault, data}

  axp_mem_port #(.ADDR_W(ADDR_W)) dut (
    .clock(clk), .reset_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_sext(req_sext), .req_addr(req_addr), .req_mask(req_mask), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
`ifdef AXP_MEM_BYTE_ENABLE_EN
    , .bus_be(bus_be)
`endif
  );

  // Bus model: observes handshakes at negedge, returns read data the cycle after accept
  int  rd_cnt = 0, wr_cnt = 0, bv_cnt = 0;
  logic [ADDR_W-4:0] last_raddr = '0, last_waddr = '0;
  logic [63:0] last_wdata = '0;
  bit  rv_armed = 1'b0, rv_model = 1'b0, auto_rv = 1'b1, rv_inject = 1'b0;
  assign bus_rvalid = rv_model | rv_inject;

  always @(negedge clk) begin
    rv_model = rv_armed && auto_rv;
    rv_armed = 1'b0;
    if (bus_valid) bv_cnt++;
    if (bus_valid && bus_ready) begin
      if (bus_write) begin
        wr_cnt++;
        last_waddr = bus_addr;
        last_wdata = bus_wdata;
`ifdef AXP_MEM_BYTE_ENABLE_EN
        last_wbe = bus_be;
`endif
      end else begin
        rd_cnt++;
        last_raddr = bus_addr;
        rv_armed = 1'b1;
      end
    end
  end

  typedef struct {
    logic [63:0] addr; logic [7:0] mask; logic sext; logic [63:0] rdata; logic [63:0] exp;
  } ld_vec_t;

  typedef struct {
    logic [63:0] addr; logic [7:0] mask; logic [63:0] data; logic [63:0] rdata;
    logic [63:0] wdata; int lat; int reads; logic [7:0] be;
  } st_vec_t;

  // Drive one request and hold it until accepted; returns #1 after the accept edge
  task automatic issue(input logic st, input logic sx, input logic [63:0] a,
                       input logic [7:0] m, input logic [63:0] d);
    bit acc = 1'b0;
    req_store = st; req_sext = sx; req_addr = a; req_mask = m; req_data = d;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (req_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!acc) begin
      vectors++; errors++;
      $display("FAIL issue_timeout addr=%h req_ready never seen", a);
    end
  endtask

  // Wait (bounded) for rsp_valid; lat counts edges from the accept edge, 0 on timeout
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      if (rsp_valid) begin lat = i; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    vectors++;
    if ({rsp_valid, rsp_fault, bus_valid, bus_write} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {rsp_valid, rsp_fault, bus_valid, bus_write});
    end
    vectors++;
    if ({rsp_data, bus_wdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h %h exp 0", rsp_data, bus_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_loads();
    ld_vec_t v [7];
    int lat, rd0;
    logic [64:0] e;
    v[0] = '{64'h0000_0000_1000_0004, 8'h0F, 1'b1, 64'h80000001_00000000, 64'hFFFFFFFF_80000001};
    v[1] = '{64'h0000_0000_1000_0007, 8'h01, 1'b1, 64'hF1223344_55667788, 64'h00000000_000000F1};
    v[2] = '{64'h0000_0000_2000_0002, 8'h03, 1'b0, 64'h11223344_55667788, 64'h00000000_00005566};
    v[3] = '{64'h0000_0000_3000_0000, 8'hFF, 1'b0, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D};
    v[4] = '{64'h0000_0000_4000_0000, 8'h0F, 1'b0, 64'h00000000_90000000, 64'h00000000_90000000};
    v[5] = '{64'h0000_0000_5000_0008, 8'h07, 1'b1, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF};
    v[6] = '{64'hFFFF_0000_0000_0004, 8'h0F, 1'b1, 64'h7FFFFFFF_00000000, 64'h00000000_7FFFFFFF};
    for (int i = 0; i < 7; i++) begin
      bus_rdata = v[i].rdata;
      exp_q.push_back({1'b0, v[i].exp});
      rd0 = rd_cnt;
      issue(1'b0, v[i].sext, v[i].addr, v[i].mask, 64'h0);
      wait_rsp(lat);
      e = exp_q.pop_front();
      vectors++;
      if (lat != 3) begin errors++; $display("FAIL load%0d_latency got %0d exp 3", i, lat); end
      vectors++;
      if ({rsp_valid, rsp_fault, rsp_data} !== {1'b1, e}) begin
        errors++; $display("FAIL load%0d_rsp got v=%b f=%b d=%h exp f=%b d=%h",
                           i, rsp_valid, rsp_fault, rsp_data, e[64], e[63:0]);
      end
      vectors++;
      if (rd_cnt - rd0 != 1 || last_raddr !== v[i].addr[63:3]) begin
        errors++; $display("FAIL load%0d_bus reads=%0d addr=%h exp 1 %h", i, rd_cnt - rd0, last_raddr, v[i].addr[63:3]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stores();
    st_vec_t v [4];
    int lat, rd0, wr0;
    logic [64:0] e;
`ifdef AXP_MEM_BYTE_ENABLE_EN
    v[0] = '{64'h3, 8'h01, 64'hAB, 64'h11223344_55667788, 64'h00000000_AB000000, 2, 0, 8'h08};
    v[1] = '{64'h8, 8'hFF, 64'h01234567_89ABCDEF, 64'h0, 64'h01234567_89ABCDEF, 2, 0, 8'hFF};
    v[2] = '{64'h6, 8'h03, 64'hBEEF, 64'h11223344_55667788, 64'hBEEF0000_00000000, 2, 0, 8'hC0};
    v[3] = '{64'h104, 8'h0F, 64'hCAFEBABE, 64'h0, 64'hCAFEBABE_00000000, 2, 0, 8'hF0};
`else
    v[0] = '{64'h3, 8'h01, 64'hAB, 64'h11223344_55667788, 64'h11223344_AB667788, 4, 1, 8'h08};
    v[1] = '{64'h8, 8'hFF, 64'h01234567_89ABCDEF, 64'h0, 64'h01234567_89ABCDEF, 2, 0, 8'hFF};
    v[2] = '{64'h6, 8'h03, 64'hBEEF, 64'h11223344_55667788, 64'hBEEF3344_55667788, 4, 1, 8'hC0};
    v[3] = '{64'h104, 8'h0F, 64'hCAFEBABE, 64'h0, 64'hCAFEBABE_00000000, 4, 1, 8'hF0};
`endif
    for (int i = 0; i < 4; i++) begin
      bus_rdata = v[i].rdata;
      exp_q.push_back({1'b0, 64'h0});
      rd0 = rd_cnt; wr0 = wr_cnt;
      issue(1'b1, 1'b0, v[i].addr, v[i].mask, v[i].data);
      wait_rsp(lat);
      e = exp_q.pop_front();
      vectors++;
      if (lat != v[i].lat) begin errors++; $display("FAIL store%0d_latency got %0d exp %0d", i, lat, v[i].lat); end
      vectors++;
      if ({rsp_valid, rsp_fault, rsp_data} !== {1'b1, e}) begin
        errors++; $display("FAIL store%0d_rsp got v=%b f=%b d=%h exp 1 0 0", i, rsp_valid, rsp_fault, rsp_data);
      end
      vectors++;
      if (rd_cnt - rd0 != v[i].reads || wr_cnt - wr0 != 1) begin
        errors++; $display("FAIL store%0d_ops reads=%0d writes=%0d exp %0d 1", i, rd_cnt - rd0, wr_cnt - wr0, v[i].reads);
      end
      vectors++;
      if (last_wdata !== v[i].wdata || last_waddr !== v[i].addr[63:3]) begin
        errors++; $display("FAIL store%0d_wdata got %h @%h exp %h @%h", i, last_wdata, last_waddr, v[i].wdata, v[i].addr[63:3]);
      end
`ifdef AXP_MEM_BYTE_ENABLE_EN
      vectors++;
      if (last_wbe !== v[i].be) begin errors++; $display("FAIL store%0d_be got %h exp %h", i, last_wbe, v[i].be); end
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_faults();
    logic [63:0] fa [4];
    logic [7:0]  fm [4];
    logic        fs [4];
    int lat, bv0;
    logic [64:0] e;
    fa[0] = 64'h5; fm[0] = 8'h03; fs[0] = 1'b0;
    fa[1] = 64'h2; fm[1] = 8'h0F; fs[1] = 1'b1;
    fa[2] = 64'h1; fm[2] = 8'hFF; fs[2] = 1'b0;
    fa[3] = 64'h4; fm[3] = 8'h07; fs[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b1, 64'h0});
      bv0 = bv_cnt;
      issue(fs[i], 1'b1, fa[i], fm[i], 64'hFFFF_FFFF_FFFF_FFFF);
      wait_rsp(lat);
      e = exp_q.pop_front();
      vectors++;
      if (lat != 1) begin errors++; $display("FAIL fault%0d_latency got %0d exp 1", i, lat); end
      vectors++;
      if ({rsp_valid, rsp_fault, rsp_data} !== {1'b1, e}) begin
        errors++; $display("FAIL fault%0d_rsp got v=%b f=%b d=%h exp 1 1 0", i, rsp_valid, rsp_fault, rsp_data);
      end
      @(posedge clk); #1;
      vectors++;
      if (bv_cnt != bv0) begin errors++; $display("FAIL fault%0d_bus bus_valid cycles=%0d exp 0", i, bv_cnt - bv0); end
    end
  endtask

  task automatic test_stall();
    logic [63:0] a = 64'h0000_0000_6000_0000;
    int lat;
    logic [64:0] e;
    bus_rdata = 64'h5555AAAA_5555AAAA;
    exp_q.push_back({1'b0, 64'h5555AAAA_5555AAAA});
    bus_ready = 1'b0;
    rsp_ready = 1'b0;
    issue(1'b0, 1'b0, a, 8'hFF, 64'h0);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({bus_valid, bus_write, bus_addr} !== {1'b1, 1'b0, a[63:3]}) begin
        errors++; $display("FAIL stall_rd%0d got v=%b w=%b a=%h exp 1 0 %h", i, bus_valid, bus_write, bus_addr, a[63:3]);
      end
`ifdef AXP_MEM_BYTE_ENABLE_EN
      vectors++;
      if (bus_be !== 8'hFF) begin errors++; $display("FAIL stall_be got %h exp ff", bus_be); end
`endif
      @(posedge clk); #1;
    end
    bus_ready = 1'b1;
    wait_rsp(lat);
    e = exp_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({rsp_valid, req_ready, rsp_fault, rsp_data} !== {1'b1, 1'b0, e}) begin
        errors++; $display("FAIL stall_rsp%0d got v=%b rdy=%b f=%b d=%h exp 1 0 %b %h",
                           i, rsp_valid, req_ready, rsp_fault, rsp_data, e[64], e[63:0]);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL stall_release got v=%b rdy=%b exp 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [64:0] e;
    auto_rv = 1'b0;
    bus_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    issue(1'b0, 1'b0, 64'h7000, 8'hFF, 64'h0);
    @(posedge clk); #1;                 // now waiting for read data
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_fault, bus_valid, bus_write} !== 5'b0 || {rsp_data, bus_wdata} !== 128'h0) begin
      errors++; $display("FAIL midreset_outputs got rdy=%b v=%b f=%b bv=%b bw=%b d=%h wd=%h exp all 0",
                         req_ready, rsp_valid, rsp_fault, bus_valid, bus_write, rsp_data, bus_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv_inject = 1'b1;
    @(posedge clk); #1;
    rv_inject = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({rsp_valid, req_ready, bus_valid} !== 3'b010) begin
        errors++; $display("FAIL midreset_idle%0d got v=%b rdy=%b bv=%b exp 0 1 0", i, rsp_valid, req_ready, bus_valid);
      end
      @(posedge clk); #1;
    end
    auto_rv = 1'b1;
    bus_rdata = 64'h00000000_0000C3A5;
    exp_q.push_back({1'b0, 64'h00000000_0000C3A5});
    issue(1'b0, 1'b0, 64'h7000, 8'h03, 64'h0);
    wait_rsp(lat);
    e = exp_q.pop_front();
    vectors++;
    if ({rsp_valid, rsp_fault, rsp_data} !== {1'b1, e} || lat != 3) begin
      errors++; $display("FAIL midreset_recover got v=%b f=%b d=%h lat=%0d exp 1 0 %h 3", rsp_valid, rsp_fault, rsp_data, lat, e[63:0]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_faults();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
